alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Operand/function issue stage directly upstream of the 16-bit combinational ALU (alu16).
//  Two-stage valid/ready pipeline:
//   - S1 registers operands and the function select, and drives the ALU inputs.
//   - S2 captures the ALU result and derives flags.
//  Keeps an accumulator (last retired ALU result) that an op may select as operand A, with same-cycle forwarding.
// PARAMETERS
//  WIDTH    16  datapath width; must match ALU a/b/alu width
//  CNTW     16  width of retired-op counter
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      upstream op valid
//  in_ready   out  1      stage can accept op this cycle
//  in_a       in   WIDTH  operand A (ignored when in_use_acc=1)
//  in_b       in   WIDTH  operand B
//  in_fs      in   2      ALU function select, passed opaque to ALU alufs
//  in_use_acc in   1      1: operand A := accumulator (forwarded)
//  acc_clr    in   1      clear accumulator to 0
//  alu_a      out  WIDTH  to ALU a   (S1 register)
//  alu_b      out  WIDTH  to ALU b   (S1 register)
//  alu_fs     out  2      to ALU alufs (S1 register)
//  alu_res    in   WIDTH  from ALU alu, combinational from alu_a/b/fs
//  out_valid  out  1      S2 result valid
//  out_ready  in   1      downstream accepts result
//  out_res    out  WIDTH  S2 result
//  out_zero   out  1      out_res == 0
//  out_neg    out  1      out_res[WIDTH-1]
//  acc        out  WIDTH  accumulator value
//  op_count   out  CNTW   retired ops (out_valid & out_ready), wraps
// BEHAVIOUR
//  Reset (sync, active-high):
//   - All registers and outputs go to 0: s1_valid, out_valid, alu_a/b/fs, out_res, out_zero, out_neg, acc, op_count.
//   - Reset overrides every other event in that cycle.
//   - A mid-operation reset drops in-flight ops silently; they are not counted.
//  Advance rules:
//   - s1_adv  = s1_valid & (!out_valid | out_ready)
//   - in_ready = !s1_valid | s1_adv   (combinational; depends on out_ready)
//   - accept  = in_valid & in_ready
//  Capture into S1 on accept:
//   - alu_b <= in_b; alu_fs <= in_fs; s1_valid <= 1.
//   - alu_a <= in_a, or A_acc when in_use_acc=1.
//   - A_acc = acc_clr ? 0 : (s1_adv ? alu_res : acc), i.e. forwards the result retiring from S1 in the same cycle.
//   - No accept and s1_adv: s1_valid <= 0; alu_a/b/fs hold their last values.
//  S2:
//   - On s1_adv: out_res <= alu_res; out_zero <= (alu_res==0); out_neg <= alu_res[WIDTH-1]; out_valid <= 1.
//   - Else if out_valid & out_ready: out_valid <= 0 and out_res holds.
//   - Else S2 holds.
//  Accumulator:
//   - acc_clr=1: acc <= 0. This has priority over the update.
//   - Else on s1_adv: acc <= alu_res.
//  op_count:
//   - +1 per out_valid & out_ready.
//   - Modulo 2^CNTW; all-ones wraps to 0.
//  Latency and throughput:
//   - Op accepted in cycle N: ALU inputs valid in N+1; out_valid in N+2 if no stall.
//   - Throughput 1 op/cycle with out_ready held high.
//  Stall:
//   - out_valid & !out_ready: S2 and S1 hold; in_ready = !s1_valid.
//   - Both full: in_ready=0. No op is ever dropped or duplicated.
//  The ALU's own reset input is tied to this block's reset at the parent.
// TESTING
//  1. Reset -> every output 0, in_ready=1.
//     Then op a=5, b=3, fs=00 with a model ALU -> out_valid 2 cycles later; out_res = model(5,3,00); op_count=1.
//  2. Back-to-back with use_acc: op1 a=0x0010 b=0x0001 (add); next cycle op2 use_acc=1 b=0x0002
//     -> op2 alu_a=0x0011 (forwarded); out_res sequence 0x0011, 0x0013.
//  3. Backpressure: out_ready=0 for 4 cycles with 3 ops offered -> 2 held (S1, S2), in_ready=0;
//     release -> all 3 retire in order, none lost.
//  4. acc_clr on the same cycle as S1 advance and use_acc accept -> acc=0 next cycle; captured alu_a=0.
//  5. Result 0x0000 -> out_zero=1; result 0x8000 -> out_neg=1, out_zero=0.
//     Preload op_count to 0xFFFF via 65535 retires -> the next retire gives 0x0000.
//  6. Reset asserted while S1 and S2 are both valid -> next cycle out_valid=0, acc=0, op_count=0, in_ready=1.

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: two-stage valid/ready issue pipeline in front of a
// combinational 16-bit ALU. S1 registers the operands and the function select
// and drives the ALU inputs. S2 captures the ALU result and derives flags.
// An accumulator holds the last result leaving S1. An op can use it as
// operand A, and a result leaving S1 in the same cycle is forwarded to it.
module alu_issue_stage #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_fs,
  input  logic             in_use_acc,
  input  logic             acc_clr,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [1:0]       alu_fs,
  input  logic [WIDTH-1:0] alu_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_neg,
  output logic [WIDTH-1:0] acc,
  output logic [CNTW-1:0]  op_count
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [1:0]       alu_fs_q, alu_fs_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic             out_zero_q, out_zero_d;
  logic             out_neg_q, out_neg_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNTW-1:0]  op_count_q, op_count_d;

  logic             s1_adv;
  logic             retire;
  logic             accept;
  logic [WIDTH-1:0] a_acc;

  // S1 moves into S2 when S2 is empty or is being drained this cycle.
  assign s1_adv   = s1_valid_q & (~out_valid_q | out_ready);
  assign retire   = out_valid_q & out_ready;
  assign in_ready = ~s1_valid_q | s1_adv;
  assign accept   = in_valid & in_ready;
  // The accumulator value an op would see. A clear wins. Otherwise the result
  // leaving S1 in this cycle is forwarded.
  assign a_acc    = acc_clr ? '0 : (s1_adv ? alu_res : acc_q);

  // Next-state logic for both pipeline stages, the accumulator and the counter.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_fs_d    = alu_fs_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_zero_d  = out_zero_q;
    out_neg_d   = out_neg_q;
    acc_d       = acc_q;
    op_count_d  = op_count_q;

    if (accept) begin
      s1_valid_d = 1'b1;
      alu_a_d    = in_use_acc ? a_acc : in_a;
      alu_b_d    = in_b;
      alu_fs_d   = in_fs;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s1_adv) begin
      out_valid_d = 1'b1;
      out_res_d   = alu_res;
      out_zero_d  = (alu_res == '0);
      out_neg_d   = alu_res[WIDTH-1];
    end else if (retire) begin
      out_valid_d = 1'b0;
    end

    if (acc_clr) begin
      acc_d = '0;
    end else if (s1_adv) begin
      acc_d = alu_res;
    end

    if (retire) begin
      op_count_d = op_count_q + CNTW'(1);
    end
  end

  // State register. Reset clears everything and overrides all other updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fs_q    <= '0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_zero_q  <= 1'b0;
      out_neg_q   <= 1'b0;
      acc_q       <= '0;
      op_count_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_fs_q    <= alu_fs_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_zero_q  <= out_zero_d;
      out_neg_q   <= out_neg_d;
      acc_q       <= acc_d;
      op_count_q  <= op_count_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_fs    = alu_fs_q;
  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_zero  = out_zero_q;
  assign out_neg   = out_neg_q;
  assign acc       = acc_q;
  assign op_count  = op_count_q;

endmodule
